// File: rtl/ibex_register_file_fpga_sb.sv
// Register file for FPGA targets: an init sequence fills the array with
// WordZeroVal, then one write port, three async read ports and per-register busy bits.
module ibex_register_file_fpga_sb #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter logic [DataWidth-1:0] WordZeroVal = '0,
  parameter bit                   WriteBypass = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [4:0]           raddr_a_i,
  input  logic [4:0]           raddr_b_i,
  input  logic [4:0]           raddr_c_i,
  output logic [DataWidth-1:0] rdata_a_o,
  output logic [DataWidth-1:0] rdata_b_o,
  output logic [DataWidth-1:0] rdata_c_o,
  input  logic [4:0]           waddr_a_i,
  input  logic [DataWidth-1:0] wdata_a_i,
  input  logic                 we_a_i,
  input  logic                 busy_set_i,
  input  logic [4:0]           busy_set_addr_i,
  output logic                 busy_a_o,
  output logic                 busy_b_o,
  output logic                 busy_c_o,
  output logic                 init_done_o,
  output logic [DataWidth-1:0] ra_o
);

  localparam int unsigned      NumWords = RV32E ? 16 : 32;
  localparam int unsigned      AddrW    = $clog2(NumWords);
  localparam logic [AddrW-1:0] LastIdx  = AddrW'(NumWords - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e               state_q;
  logic [AddrW-1:0]     cnt_q;
  logic                 init_done_q;
  logic [DataWidth-1:0] mem [NumWords];
  logic [NumWords-1:0]  busy_q;

  logic                 we_valid;
  logic                 set_valid;
  logic [4:0]           raddr [3];
  logic [DataWidth-1:0] rdata [3];
  logic                 rbusy [3];

  // Address 0 is hardwired to zero; RV32E has no registers with bit 4 set.
  function automatic logic addr_valid(input logic [4:0] a);
    return (a != 5'd0) && !(RV32E && a[4]);
  endfunction

  assign we_valid  = (state_q == RUN) && we_a_i && addr_valid(waddr_a_i);
  assign set_valid = (state_q == RUN) && busy_set_i && addr_valid(busy_set_addr_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= AddrW'(1);
      init_done_q <= 1'b0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + AddrW'(1);
      if (cnt_q == LastIdx) begin
        state_q     <= RUN;
        init_done_q <= 1'b1;
      end
    end
  end

  // No reset on the array itself so it can map onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        mem[cnt_q] <= WordZeroVal;
      end else if (we_valid) begin
        mem[waddr_a_i[AddrW-1:0]] <= wdata_a_i;
      end
    end
  end

  // The set is scheduled after the clear so a same-address collision leaves it set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      if (we_valid) begin
        busy_q[waddr_a_i[AddrW-1:0]] <= 1'b0;
      end
      if (set_valid) begin
        busy_q[busy_set_addr_i[AddrW-1:0]] <= 1'b1;
      end
    end
  end

  assign raddr = '{raddr_a_i, raddr_b_i, raddr_c_i};

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (addr_valid(raddr[p])) begin
        rbusy[p] = busy_q[raddr[p][AddrW-1:0]];
        if (state_q == INIT) begin
          rdata[p] = WordZeroVal;
        end else if (WriteBypass && we_valid && (waddr_a_i == raddr[p])) begin
          rdata[p] = wdata_a_i;
        end else begin
          rdata[p] = mem[raddr[p][AddrW-1:0]];
        end
      end
    end
  end

  assign rdata_a_o   = rdata[0];
  assign rdata_b_o   = rdata[1];
  assign rdata_c_o   = rdata[2];
  assign busy_a_o    = rbusy[0];
  assign busy_b_o    = rbusy[1];
  assign busy_c_o    = rbusy[2];
  assign init_done_o = init_done_q;
  assign ra_o        = (state_q == INIT) ? WordZeroVal : mem[AddrW'(1)];

endmodule

// File: tb/tb_ibex_register_file_fpga_sb.sv
// Bench: two register-file configurations driven by shared stimulus and checked
// every cycle against an array-based model, plus directed literal checks.
module tb_ibex_register_file_fpga_sb;

  localparam logic [31:0] WzvA = 32'hA5A5_0000;
  localparam logic [31:0] WzvE = 32'h0000_5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr [3];
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        we;
  logic        bset;
  logic [4:0]  baddr;

  logic [31:0] rdata [2][3];
  logic        rbusy [2][3];
  logic [31:0] ra [2];
  logic        done [2];

  int passCount  = 0;
  int totalCount = 0;

  always #5 clk = ~clk;

  ibex_register_file_fpga_sb #(
    .RV32E(1'b0), .DataWidth(32), .WordZeroVal(WzvA), .WriteBypass(1'b1)
  ) dut_a (
    .clk_i(clk), .rst_i(rst),
    .raddr_a_i(raddr[0]), .raddr_b_i(raddr[1]), .raddr_c_i(raddr[2]),
    .rdata_a_o(rdata[0][0]), .rdata_b_o(rdata[0][1]), .rdata_c_o(rdata[0][2]),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .busy_set_i(bset), .busy_set_addr_i(baddr),
    .busy_a_o(rbusy[0][0]), .busy_b_o(rbusy[0][1]), .busy_c_o(rbusy[0][2]),
    .init_done_o(done[0]), .ra_o(ra[0])
  );

  ibex_register_file_fpga_sb #(
    .RV32E(1'b1), .DataWidth(32), .WordZeroVal(WzvE), .WriteBypass(1'b0)
  ) dut_e (
    .clk_i(clk), .rst_i(rst),
    .raddr_a_i(raddr[0]), .raddr_b_i(raddr[1]), .raddr_c_i(raddr[2]),
    .rdata_a_o(rdata[1][0]), .rdata_b_o(rdata[1][1]), .rdata_c_o(rdata[1][2]),
    .waddr_a_i(waddr), .wdata_a_i(wdata), .we_a_i(we),
    .busy_set_i(bset), .busy_set_addr_i(baddr),
    .busy_a_o(rbusy[1][0]), .busy_b_o(rbusy[1][1]), .busy_c_o(rbusy[1][2]),
    .init_done_o(done[1]), .ra_o(ra[1])
  );

  // Model: instance 0 is 32 regs with bypass, instance 1 is RV32E without bypass.
  logic [31:0] mMem [2][32];
  bit          mBusy [2][32];
  bit          mInit [2];
  int          mInitCnt [2];
  bit          modelValid = 1'b0;

  function automatic int numWords(input int i);
    return (i == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] wzv(input int i);
    return (i == 0) ? WzvA : WzvE;
  endfunction

  function automatic bit mValid(input int i, input logic [4:0] a);
    return (a != 5'd0) && !(i == 1 && a[4]);
  endfunction

  function automatic logic [31:0] expRead(input int i, input logic [4:0] a);
    if (!mValid(i, a)) return 32'd0;
    if (mInit[i]) return wzv(i);
    if (i == 0 && we && mValid(i, waddr) && waddr == a) return wdata;
    return mMem[i][a];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      modelValid <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        mInit[i]    <= 1'b1;
        mInitCnt[i] <= 0;
        for (int j = 0; j < 32; j++) mBusy[i][j] <= 1'b0;
      end
    end else if (modelValid) begin
      for (int i = 0; i < 2; i++) begin
        if (mInit[i]) begin
          mInitCnt[i] <= mInitCnt[i] + 1;
          if (mInitCnt[i] + 1 == numWords(i) - 1) begin
            mInit[i] <= 1'b0;
            for (int j = 1; j < numWords(i); j++) mMem[i][j] <= wzv(i);
          end
        end else begin
          if (we && mValid(i, waddr)) begin
            mMem[i][waddr]  <= wdata;
            mBusy[i][waddr] <= 1'b0;
          end
          if (bset && mValid(i, baddr)) mBusy[i][baddr] <= 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    #2;
    if (modelValid) begin
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 3; p++) begin
          checkOutput($sformatf("rdata[%0d][%0d] addr %0d", i, p, raddr[p]), rdata[i][p], expRead(i, raddr[p]));
          checkOutput($sformatf("busy[%0d][%0d] addr %0d", i, p, raddr[p]), 32'(rbusy[i][p]),
                      32'(mValid(i, raddr[p]) ? mBusy[i][raddr[p]] : 1'b0));
        end
        checkOutput($sformatf("ra[%0d]", i), ra[i], mInit[i] ? wzv(i) : mMem[i][1]);
        checkOutput($sformatf("init_done[%0d]", i), 32'(done[i]), 32'(!mInit[i]));
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic s, input logic [4:0] sa,
                               input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    rst = r; we = w; waddr = wa; wdata = wd; bset = s; baddr = sa;
    raddr[0] = a0; raddr[1] = a1; raddr[2] = a2;
  endtask

  // Counts cycles after reset release until each instance reports init done.
  task automatic measureInit(output int lenA, output int lenE);
    lenA = 0; lenE = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      #1;
      if (done[0] && lenA == 0) lenA = cyc;
      if (done[1] && lenE == 0) lenE = cyc;
    end
  endtask

  initial begin
    int lenA, lenE;
    logic [4:0] a0, wa;
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; bset = 1'b0; baddr = '0;
    raddr[0] = 5'd3; raddr[1] = 5'd0; raddr[2] = 5'd31;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset init_done A", 32'(done[0]), 32'd0);
    checkOutput("reset init_done E", 32'(done[1]), 32'd0);

    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 31);
    measureInit(lenA, lenE);
    checkOutput("init length A", lenA, 31);
    checkOutput("init length E", lenE, 15);
    checkOutput("x3 after init A", rdata[0][0], 32'hA5A5_0000);
    checkOutput("x0 after init A", rdata[0][1], 32'd0);
    checkOutput("x31 after init A", rdata[0][2], 32'hA5A5_0000);
    checkOutput("ra after init E", ra[1], 32'h0000_5A5A);

    applyStimulus(0, 1, 5, 32'h1234_5678, 0, 0, 5, 0, 0);
    #1;
    checkOutput("x5 bypass A", rdata[0][0], 32'h1234_5678);
    checkOutput("x5 old value E", rdata[1][0], 32'h0000_5A5A);
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0, 0);
    #1;
    checkOutput("x5 readback A", rdata[0][0], 32'h1234_5678);
    checkOutput("x5 readback E", rdata[1][0], 32'h1234_5678);

    applyStimulus(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("x0 after write A", rdata[0][0], 32'd0);

    applyStimulus(0, 1, 7, 32'hDEAD_BEEF, 0, 0, 0, 7, 0);
    #1;
    checkOutput("x7 bypass A", rdata[0][1], 32'hDEAD_BEEF);
    checkOutput("x7 no bypass E", rdata[1][1], 32'h0000_5A5A);

    applyStimulus(0, 0, 0, 0, 1, 9, 9, 0, 0);
    #1;
    checkOutput("busy x9 before edge", 32'(rbusy[0][0]), 32'd0);
    applyStimulus(0, 1, 9, 32'h1, 1, 9, 9, 0, 0);
    #1;
    checkOutput("busy x9 set", 32'(rbusy[0][0]), 32'd1);
    applyStimulus(0, 1, 9, 32'h2, 0, 0, 9, 0, 0);
    #1;
    checkOutput("busy x9 set wins", 32'(rbusy[0][0]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 9, 0, 0);
    #1;
    checkOutput("busy x9 cleared A", 32'(rbusy[0][0]), 32'd0);
    checkOutput("busy x9 cleared E", 32'(rbusy[1][0]), 32'd0);

    applyStimulus(0, 1, 20, 32'hCAFE_0001, 1, 20, 20, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 20, 0, 0);
    #1;
    checkOutput("x20 dropped E", rdata[1][0], 32'd0);
    checkOutput("x20 not busy E", 32'(rbusy[1][0]), 32'd0);
    checkOutput("x20 written A", rdata[0][0], 32'hCAFE_0001);
    checkOutput("x20 busy A", 32'(rbusy[0][0]), 32'd1);

    applyStimulus(0, 1, 3, 32'h3333_3333, 0, 0, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 0);
    #1;
    checkOutput("x3 written A", rdata[0][0], 32'h3333_3333);
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 0);
    repeat (9) applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 3, 0, 0);
    measureInit(lenA, lenE);
    checkOutput("reinit length A", lenA, 31);
    checkOutput("x3 after reinit A", rdata[0][0], 32'hA5A5_0000);
    checkOutput("x3 after reinit E", rdata[1][0], 32'h0000_5A5A);

    for (int n = 0; n < 3000; n++) begin
      a0 = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 9));
      wa = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
      applyStimulus($urandom_range(0, 399) == 0, 1'($urandom), wa, $urandom,
                    1'($urandom), ($urandom_range(0, 1) == 0) ? a0 : 5'($urandom_range(0, 31)),
                    a0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 9)));
    end

    @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
